// File: rtl/block_stage_controller_if.sv
// Command and read-port bundle between the stage controller and the 30x10 block memory.
interface block_stage_controller_if;
  logic       mem_enable;
  logic [1:0] mem_func;
  logic [1:0] mem_stage;
  logic [4:0] mem_row;
  logic [4:0] mem_col;
  logic [2:0] mem_block;
  logic       mem_busy;

  modport master (
    output mem_enable, mem_func, mem_stage, mem_row, mem_col,
    input  mem_block, mem_busy
  );

  modport slave (
    input  mem_enable, mem_func, mem_stage, mem_row, mem_col,
    output mem_block, mem_busy
  );
endinterface

// File: rtl/block_stage_controller.sv
// Stage sequencer: issues LOAD/DROP to the block memory, counts remaining blocks by a
// full board scan, and advances stages until the last one is cleared.
//
// state   | meaning
// IDLE    | no game running, waiting for start
// CMD     | command pending, strobes once when memory is not busy
// WAIT_HI | strobe sent, waiting for memory to raise busy
// WAIT_LO | memory busy, waiting for it to finish
// SCAN    | walking all cells row-major and counting non-zero blocks
// PLAY    | board stable, accepting drop_tick / rescan
// CLEAR   | zero blocks found, pulse stage_clear and pick next step
// WON     | last stage cleared, waiting for start
module block_stage_controller #(
  parameter int MAXROW     = 30,
  parameter int MAXCOL     = 10,
  parameter int LAST_STAGE = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        drop_tick,
  input  logic        rescan,
  input  logic [4:0]  ext_row,
  input  logic [4:0]  ext_col,
  block_stage_controller_if.master mem,
  output logic [1:0]  stage,
  output logic [8:0]  blocks_left,
  output logic        stage_clear,
  output logic        game_won,
  output logic        ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WAIT_HI, S_WAIT_LO, S_SCAN, S_PLAY, S_CLEAR, S_WON
  } state_t;

  // 2'b10 (PULL) is accepted by CMD but no trigger currently selects it.
  localparam logic [1:0] FUNC_LOAD   = 2'b01;
  localparam logic [1:0] FUNC_DROP   = 2'b11;
  localparam logic [4:0] ROW_END     = 5'(MAXROW - 1);
  localparam logic [4:0] COL_END     = 5'(MAXCOL - 1);
  localparam logic [1:0] STAGE_FINAL = 2'(LAST_STAGE);

  state_t     r_state, w_next;
  logic [1:0] r_func;
  logic [1:0] r_stage;
  logic [8:0] r_blocks_left;
  logic [8:0] r_count;
  logic [4:0] r_row, r_col;
  logic       r_drain;
  logic       r_sample;
  logic       r_pending;

  logic       w_strobe, w_scan_start, w_scan_done;
  logic       w_new_game, w_drop_cmd, w_next_stage;
  logic       w_hit;
  logic [8:0] w_count_next;

  // mem_block answers for the address presented on the previous cycle.
  assign w_hit        = r_sample && (mem.mem_block != 3'd0);
  assign w_count_next = r_count + {8'd0, w_hit};

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_strobe     = 1'b0;
    w_scan_start = 1'b0;
    w_scan_done  = 1'b0;
    w_new_game   = 1'b0;
    w_drop_cmd   = 1'b0;
    w_next_stage = 1'b0;
    stage_clear  = 1'b0;
    case (r_state)
      S_IDLE, S_WON: begin
        if (start) begin
          w_new_game = 1'b1;
          w_next     = S_CMD;
        end
      end
      S_CMD: begin
        if (!mem.mem_busy) begin
          w_strobe = 1'b1;
          w_next   = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (mem.mem_busy) w_next = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!mem.mem_busy) begin
          w_scan_start = 1'b1;
          w_next       = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_drain) begin
          w_scan_done = 1'b1;
          w_next      = (w_count_next == 9'd0) ? S_CLEAR : S_PLAY;
        end
      end
      S_PLAY: begin
        if (drop_tick) begin
          w_drop_cmd = 1'b1;
          w_next     = S_CMD;
        end else if (rescan || r_pending) begin
          w_scan_start = 1'b1;
          w_next       = S_SCAN;
        end
      end
      S_CLEAR: begin
        stage_clear = 1'b1;
        if (r_stage == STAGE_FINAL) begin
          w_next = S_WON;
        end else begin
          w_next_stage = 1'b1;
          w_next       = S_CMD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_func        <= 2'b00;
      r_stage       <= 2'd0;
      r_blocks_left <= 9'd0;
      r_count       <= 9'd0;
      r_row         <= 5'd0;
      r_col         <= 5'd0;
      r_drain       <= 1'b0;
      r_sample      <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      if (w_new_game) begin
        r_stage <= 2'd0;
        r_func  <= FUNC_LOAD;
      end
      if (w_next_stage) begin
        r_stage <= r_stage + 2'd1;
        r_func  <= FUNC_LOAD;
      end
      if (w_drop_cmd) r_func <= FUNC_DROP;

      // Any scan satisfies an outstanding recount request.
      if (w_scan_start)  r_pending <= 1'b0;
      else if (rescan)   r_pending <= 1'b1;

      if (w_scan_start) begin
        r_row    <= 5'd0;
        r_col    <= 5'd0;
        r_drain  <= 1'b0;
        r_sample <= 1'b0;
        r_count  <= 9'd0;
      end else if (r_state == S_SCAN) begin
        r_count <= w_count_next;
        if (!r_drain) begin
          r_sample <= 1'b1;
          if (r_row == ROW_END && r_col == COL_END) begin
            r_drain <= 1'b1;
          end else if (r_col == COL_END) begin
            r_col <= 5'd0;
            r_row <= r_row + 5'd1;
          end else begin
            r_col <= r_col + 5'd1;
          end
        end
      end

      if (w_scan_done) r_blocks_left <= w_count_next;
    end
  end

  assign mem.mem_enable = w_strobe;
  assign mem.mem_func   = (r_state == S_CMD)  ? r_func  : 2'b00;
  assign mem.mem_stage  = (r_state == S_CMD)  ? r_stage : 2'd0;
  assign mem.mem_row    = (r_state == S_SCAN) ? r_row   : ext_row;
  assign mem.mem_col    = (r_state == S_SCAN) ? r_col   : ext_col;

  assign stage       = r_stage;
  assign blocks_left = r_blocks_left;
  assign game_won    = (r_state == S_WON);
  assign ready       = (r_state == S_PLAY);

endmodule

// File: tb/tb_block_stage_controller.sv
// Directed sequence against a block-memory model with randomized boards; expected counts
// come from a population count of the model board.
module tb_block_stage_controller;
  logic       clock = 1'b0;
  logic       reset, start, drop_tick, rescan;
  logic [4:0] ext_row, ext_col;
  logic [1:0] stage;
  logic [8:0] blocks_left;
  logic       stage_clear, game_won, ready;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  block_stage_controller_if mem_if();

  block_stage_controller dut (
    .clock(clock), .reset(reset), .start(start), .drop_tick(drop_tick), .rescan(rescan),
    .ext_row(ext_row), .ext_col(ext_col), .mem(mem_if),
    .stage(stage), .blocks_left(blocks_left), .stage_clear(stage_clear),
    .game_won(game_won), .ready(ready)
  );

  // Block memory model: 300 cells, busy for BUSY_LEN cycles after each command.
  localparam int BUSY_LEN = 61;
  logic [2:0] board [300];
  int         busy_left = 0;
  logic       force_busy = 1'b0;
  int         bad_strobe = 0;
  logic [1:0] q_func[$];
  logic [1:0] q_stage[$];

  assign mem_if.mem_busy = (busy_left != 0) || force_busy;

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < 300; i++) if (board[i] != 3'd0) c++;
    return c;
  endfunction

  function automatic void clear_board();
    for (int i = 0; i < 300; i++) board[i] = 3'd0;
  endfunction

  function automatic void apply_cmd(input logic [1:0] f, input logic [1:0] s);
    int n, placed, idx;
    if (f == 2'b01) begin
      clear_board();
      n = (s == 2'd0) ? 42 : int'($urandom_range(20, 150));
      placed = 0;
      while (placed < n) begin
        idx = int'($urandom_range(0, 299));
        if (board[idx] == 3'd0) begin
          board[idx] = 3'($urandom_range(1, 7));
          placed++;
        end
      end
    end else if (f == 2'b11) begin
      for (int r = 29; r > 0; r--)
        for (int c = 0; c < 10; c++) board[r*10+c] = board[(r-1)*10+c];
      for (int c = 0; c < 10; c++) board[c] = 3'd0;
    end
  endfunction

  always @(posedge clock) begin
    if (busy_left != 0) busy_left <= busy_left - 1;
    if (mem_if.mem_enable === 1'b1) begin
      if (mem_if.mem_busy) bad_strobe = bad_strobe + 1;
      q_func.push_back(mem_if.mem_func);
      q_stage.push_back(mem_if.mem_stage);
      busy_left <= BUSY_LEN;
      apply_cmd(mem_if.mem_func, mem_if.mem_stage);
    end
    if (mem_if.mem_row < 5'd30 && mem_if.mem_col < 5'd10)
      mem_if.mem_block <= board[int'(mem_if.mem_row)*10 + int'(mem_if.mem_col)];
    else
      mem_if.mem_block <= 3'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ends on the negedge of the first SCAN cycle after the command completes.
  task automatic wait_cmd_done();
    int n1 = 0;
    int n2 = 0;
    while (mem_if.mem_busy !== 1'b1 && n1 < 100) begin @(negedge clock); n1++; end
    while (mem_if.mem_busy !== 1'b0 && n2 < 300) begin @(negedge clock); n2++; end
    check("cmd_busy_cycle_in_time", 32'(n1 < 100 && n2 < 300), 32'd1);
    @(negedge clock);
  endtask

  // Called on the negedge of scan cycle 0; ends on the negedge after the drain cycle.
  task automatic scan_check(input int exp_count, input int rescan_at, input int old_bl);
    int bad_idx = -1;
    for (int i = 0; i < 300; i++) begin
      if (bad_idx < 0 && (mem_if.mem_row !== 5'(i / 10) || mem_if.mem_col !== 5'(i % 10)
                          || ready !== 1'b0 || blocks_left !== 9'(old_bl)))
        bad_idx = i;
      rescan = (i == rescan_at);
      @(negedge clock);
    end
    rescan = 1'b0;
    check("scan_order_first_bad_index", 32'(bad_idx), 32'hFFFF_FFFF);
    check("drain_ready_low", 32'(ready), 32'd0);
    check("drain_blocks_left_held", 32'(blocks_left), 32'(old_bl));
    @(negedge clock);
    check("scan_blocks_left", 32'(blocks_left), 32'(exp_count));
    if (exp_count == 0) check("stage_clear_pulse", 32'(stage_clear), 32'd1);
    else                check("ready_after_scan", 32'(ready), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clock); start = 1'b0;
  endtask

  task automatic pulse_rescan();
    rescan = 1'b1; @(negedge clock); rescan = 1'b0;
  endtask

  task automatic pulse_drop();
    drop_tick = 1'b1; @(negedge clock); drop_tick = 1'b0;
  endtask

  initial begin
    int exp_bl, exp, flag, stg;
    reset = 1'b1; start = 1'b0; drop_tick = 1'b0; rescan = 1'b0;
    ext_row = 5'd7; ext_col = 5'd3;
    mem_if.mem_block = 3'd0;
    clear_board();
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_blocks_left", 32'(blocks_left), 32'd0);
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_game_won", 32'(game_won), 32'd0);
    check("rst_stage_clear", 32'(stage_clear), 32'd0);
    check("rst_mem_enable", 32'(mem_if.mem_enable), 32'd0);
    check("rst_mem_func", 32'(mem_if.mem_func), 32'd0);
    check("rst_passthrough_row", 32'(mem_if.mem_row), 32'd7);
    check("rst_passthrough_col", 32'(mem_if.mem_col), 32'd3);
    reset = 1'b0;
    ext_row = 5'd31; ext_col = 5'd31;
    @(negedge clock);

    // New game: LOAD stage 0, scan 42 blocks.
    q_func.delete(); q_stage.delete();
    pulse_start();
    check("start_strobe", 32'(mem_if.mem_enable), 32'd1);
    check("start_func_load", 32'(mem_if.mem_func), 32'd1);
    check("start_mem_stage", 32'(mem_if.mem_stage), 32'd0);
    wait_cmd_done();
    scan_check(42, -1, 0);
    exp_bl = 42;
    check("load_strobe_count", 32'(q_func.size()), 32'd1);
    check("load_logged_func", 32'(q_func[0]), 32'd1);
    check("load_logged_stage", 32'(q_stage[0]), 32'd0);

    // drop_tick and rescan together: one DROP then exactly one scan.
    q_func.delete(); q_stage.delete();
    drop_tick = 1'b1; rescan = 1'b1;
    @(negedge clock);
    drop_tick = 1'b0; rescan = 1'b0;
    check("drop_strobe", 32'(mem_if.mem_enable), 32'd1);
    check("drop_func", 32'(mem_if.mem_func), 32'd3);
    wait_cmd_done();
    exp = popcount();
    scan_check(exp, -1, exp_bl);
    exp_bl = exp;
    flag = 0;
    repeat (20) begin @(negedge clock); if (ready !== 1'b1) flag = 1; end
    check("no_second_scan_after_drop", 32'(flag), 32'd0);
    check("drop_strobe_count", 32'(q_func.size()), 32'd1);
    check("drop_logged_func", 32'(q_func[0]), 32'd3);

    // Start while playing is ignored.
    pulse_start();
    flag = 0;
    repeat (5) begin if (mem_if.mem_enable !== 1'b0 || ready !== 1'b1) flag = 1; @(negedge clock); end
    check("start_ignored_in_play", 32'(flag), 32'd0);

    // Random further drops.
    repeat (2) begin
      q_func.delete(); q_stage.delete();
      pulse_drop();
      wait_cmd_done();
      exp = popcount();
      scan_check(exp, -1, exp_bl);
      exp_bl = exp;
      check("rand_drop_strobe_count", 32'(q_func.size()), 32'd1);
    end

    // Rescan arriving mid-scan is remembered and triggers a second scan.
    pulse_rescan();
    exp = popcount();
    scan_check(exp, int'($urandom_range(1, 250)), exp_bl);
    exp_bl = exp;
    @(negedge clock);
    scan_check(exp, -1, exp_bl);

    // Clear stages 0 and 1; stage 2 LOAD is held off by a busy memory.
    for (int s = 0; s < 2; s++) begin
      q_func.delete(); q_stage.delete();
      clear_board();
      force_busy = (s == 1);
      pulse_rescan();
      scan_check(0, -1, exp_bl);
      exp_bl = 0;
      @(negedge clock);
      check("clear_pulse_one_cycle", 32'(stage_clear), 32'd0);
      check("stage_advanced", 32'(stage), 32'(s + 1));
      if (s == 1) begin
        flag = 0;
        repeat (8) begin if (mem_if.mem_enable !== 1'b0) flag = 1; @(negedge clock); end
        check("no_strobe_while_busy", 32'(flag), 32'd0);
        force_busy = 1'b0;
        #1;
      end
      check("next_load_strobe", 32'(mem_if.mem_enable), 32'd1);
      check("next_load_func", 32'(mem_if.mem_func), 32'd1);
      check("next_load_stage", 32'(mem_if.mem_stage), 32'(s + 1));
      wait_cmd_done();
      exp = popcount();
      scan_check(exp, -1, 0);
      exp_bl = exp;
      check("next_load_strobe_count", 32'(q_func.size()), 32'd1);
    end

    // Stage 2 -> 3, then clear the last stage.
    for (stg = 2; stg <= 3; stg++) begin
      q_func.delete(); q_stage.delete();
      clear_board();
      pulse_rescan();
      scan_check(0, -1, exp_bl);
      exp_bl = 0;
      @(negedge clock);
      if (stg == 2) begin
        check("stage3_load_stage", 32'(mem_if.mem_stage), 32'd3);
        wait_cmd_done();
        exp = popcount();
        scan_check(exp, -1, 0);
        exp_bl = exp;
      end
    end
    check("won_level", 32'(game_won), 32'd1);
    check("won_no_strobe", 32'(mem_if.mem_enable), 32'd0);
    pulse_drop();
    pulse_rescan();
    flag = 0;
    repeat (10) begin if (game_won !== 1'b1 || mem_if.mem_enable !== 1'b0) flag = 1; @(negedge clock); end
    check("won_holds", 32'(flag), 32'd0);
    check("won_no_load_issued", 32'(q_func.size()), 32'd0);
    check("won_stage", 32'(stage), 32'd3);

    // Restart from WON.
    q_func.delete(); q_stage.delete();
    pulse_start();
    check("restart_game_won_low", 32'(game_won), 32'd0);
    check("restart_stage", 32'(stage), 32'd0);
    check("restart_strobe", 32'(mem_if.mem_enable), 32'd1);
    check("restart_func", 32'(mem_if.mem_func), 32'd1);
    check("restart_mem_stage", 32'(mem_if.mem_stage), 32'd0);
    wait_cmd_done();
    scan_check(42, -1, 0);
    exp_bl = 42;

    // Reset in the middle of a scan, at cell 150.
    pulse_rescan();
    repeat (150) @(negedge clock);
    check("midscan_row", 32'(mem_if.mem_row), 32'd15);
    check("midscan_col", 32'(mem_if.mem_col), 32'd0);
    reset = 1'b1;
    ext_row = 5'd9; ext_col = 5'd4;
    @(negedge clock);
    check("abort_blocks_left", 32'(blocks_left), 32'd0);
    check("abort_mem_enable", 32'(mem_if.mem_enable), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_stage", 32'(stage), 32'd0);
    check("abort_row_passthrough", 32'(mem_if.mem_row), 32'd9);
    check("abort_col_passthrough", 32'(mem_if.mem_col), 32'd4);
    reset = 1'b0;
    q_func.delete(); q_stage.delete();
    flag = 0;
    repeat (20) begin @(negedge clock); if (ready !== 1'b0 || mem_if.mem_enable !== 1'b0) flag = 1; end
    check("abort_stays_idle", 32'(flag), 32'd0);
    check("abort_no_reissue", 32'(q_func.size()), 32'd0);
    check("never_strobe_while_busy", 32'(bad_strobe), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/block_stage_controller.md
Name: block_stage_controller

Overview:
- Initiator-side sequencer for the 30x10 block memory: issues LOAD/PULL/DROP commands with the enable/func/busy handshake and owns the first read port during board scans.
- Scans all 300 cells to count the remaining blocks, detects stage clear, advances the stage and detects game won.
- Sits between game control (start, drop timer, rescan requests from collision logic) and the block memory.
- Forwards renderer read addresses to the block memory when not scanning.

Parameters:
- MAXROW, 30, rows per board (0..29)
- MAXCOL, 10, columns per row (0..9)
- LAST_STAGE, 3, highest stage index; clearing this stage wins the game

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse: begin a new game at stage 0
- drop_tick  in  1  pulse: request a DROP of the board
- rescan  in  1  pulse: blocks changed, recount required
- ext_row  in  5  renderer read row
- ext_col  in  5  renderer read column
- mem_enable  out  1  command strobe to block memory
- mem_func  out  2  command: 01 LOAD, 10 PULL, 11 DROP
- mem_stage  out  2  stage for LOAD
- mem_row  out  5  read-port row to block memory
- mem_col  out  5  read-port column to block memory
- mem_block  in  3  block value at (mem_row, mem_col), valid one cycle after address
- mem_busy  in  1  block memory busy
- stage  out  2  current stage
- blocks_left  out  9  non-zero block count from the last completed scan
- stage_clear  out  1  one-cycle pulse on a zero count
- game_won  out  1  level: last stage cleared
- ready  out  1  high in PLAY only

Behaviour:
- Reset: state IDLE; mem_enable=0, mem_func=00, mem_stage=0, stage=0, blocks_left=0, stage_clear=0, game_won=0, ready=0, pending rescan cleared. Reset mid-command or mid-scan aborts immediately; no command is re-issued.
- States: IDLE, CMD, WAIT_HI, WAIT_LO, SCAN, PLAY, CLEAR, WON.
- IDLE: on start, set stage=0, game_won=0, and go to CMD with LOAD.
- CMD:
  - Asserts mem_enable for exactly one cycle with mem_func/mem_stage, and only while mem_busy=0.
  - If mem_busy=1, holds mem_enable low and waits.
- WAIT_HI: waits for mem_busy=1. WAIT_LO: waits for mem_busy=0, then goes to SCAN.
- A new command is never issued while mem_busy=1 or between strobe and busy fall.
- SCAN:
  - mem_row/mem_col driven internally, row-major: (0,0),(0,1)..(0,9),(1,0)..(29,9).
  - One address per cycle.
  - mem_block sampled the following cycle. The counter increments when mem_block != 0.
  - Duration: 300 address cycles + 1 drain cycle. blocks_left updates once, at scan end; it holds its old value during the scan.
  - Count width: 9 bits, max 300, no overflow.
- End of scan: count 0 goes to CLEAR; otherwise goes to PLAY.
- Outside SCAN: mem_row=ext_row, mem_col=ext_col, combinationally.
- PLAY (ready=1):
  - drop_tick goes to CMD with DROP.
  - Otherwise, rescan (or pending rescan) goes to SCAN.
  - drop_tick and rescan in the same cycle: DROP first, and the pending flag is set. The scan after DROP clears the pending flag, since it satisfies the request.
  - rescan/drop_tick outside PLAY: drop_tick is ignored; rescan sets pending.
- CLEAR:
  - stage_clear=1 for one cycle.
  - If stage==LAST_STAGE, go to WON. Otherwise stage increments and the block goes to CMD with LOAD of the new stage.
- WON: game_won=1 and stays there; start restarts as from IDLE.
- start in any other state is ignored.
- PULL encoding is supported by CMD but is not issued by this block's current triggers; it is reserved.

Test Plan:
- Reset, start, with a memory model (busy high 61 cycles, stage 0 has 42 blocks):
  - expected: exactly one mem_enable with func=01, stage=0;
  - expected: scan visits 300 addresses in row-major order;
  - expected: blocks_left=42, ready=1.
- In PLAY, pulse drop_tick and rescan in the same cycle:
  - expected: one DROP strobe, func=11;
  - expected: exactly one scan afterward, then PLAY.
- Model clears all blocks, rescan:
  - expected: blocks_left=0, one stage_clear pulse, stage=1;
  - expected: LOAD strobe with mem_stage=1.
- Clear stage 3:
  - expected: stage_clear pulse, game_won=1, no LOAD issued;
  - then start: game_won=0, LOAD with stage 0.
- Hold mem_busy=1 when CMD is entered:
  - expected: mem_enable stays 0 until busy falls, then exactly one strobe.
- Assert reset mid-scan at cell 150:
  - expected next cycle: IDLE, blocks_left=0, mem_enable=0, ready=0;
  - expected: ext_row/ext_col pass through to mem_row/mem_col.
